ram_single_port_param: RTL
==========================

// Module: ram_single_port_param
// PURPOSE
// - Parametrised single-port synchronous RAM: one address port shared by read and write.
// - Adds over the fixed 8x64 RAM: sized width/depth, selectable write mode, access enable,
//   read-valid strobe, and a post-reset clear sequencer that zero-fills the array.
// - Generic scratch/buffer memory for datapath blocks needing one access per cycle.
// PARAMETERS
// - DATA_WIDTH  8  word width in bits
// - ADDR_WIDTH  6  address width; DEPTH = 2**ADDR_WIDTH words
// - WRITE_MODE  0  0=READ_FIRST (old data out), 1=WRITE_FIRST (new data out), 2=NO_CHANGE (data_out held)
// PORTS
// - clk        in   1           clock, all state on rising edge
// - rst        in   1           asynchronous, active-high reset
// - en_in      in   1           access request; sampled each rising edge
// - we_in      in   1           1=write, 0=read; qualified by en_in
// - addr_in    in   ADDR_WIDTH  word address
// - data_in    in   DATA_WIDTH  write data
// - data_out   out  DATA_WIDTH  registered read/write-through data
// - valid_out  out  1           data_out carries result of an accepted access (1-cycle pulse per access)
// - busy_out   out  1           clear sequence running; requests ignored
// BEHAVIOUR
// - Reset (async assert, any time): state=CLEAR, clr_addr=0, data_out=0, valid_out=0, busy_out=1.
//   Reset mid-operation discards any in-flight result; array contents not guaranteed until CLEAR completes.
// - FSM states: CLEAR, READY. No other states.
// - CLEAR: each edge writes 0 to mem[clr_addr], clr_addr+1; edge that writes DEPTH-1 moves to READY.
//   Exactly DEPTH edges after reset release; busy_out=0 from the first READY cycle.
//   en_in/we_in ignored in CLEAR: no write, no valid_out, data_out stays 0.
// - READY, en_in=1, we_in=1: mem[addr_in]<=data_in at the edge. data_out per WRITE_MODE:
//   0 -> old mem[addr_in]; 1 -> data_in; 2 -> unchanged. valid_out=1 next cycle for modes 0/1, 0 for mode 2.
// - READY, en_in=1, we_in=0: data_out<=mem[addr_in]; valid_out=1 next cycle.
// - READY, en_in=0: no write; data_out holds last value; valid_out=0.
// - Latency: 1 clock from request edge to data_out/valid_out (base build).
// - Back-to-back accesses every cycle allowed; read after write to same address on next edge
//   returns new data in all modes.
// - Address wraps naturally at ADDR_WIDTH bits; no out-of-range case exists.
// - clr_addr counter is ADDR_WIDTH bits; terminal compare on all-ones, never wraps to re-clear.
// CONFIGURATION
// - RAM_OUT_REG_EN defined: extra output pipeline stage after the array read register;
//   data_out and valid_out delayed one more clock (latency 2), both reset to 0, stage
//   follows the same hold rule (holds data when no valid enters). busy_out timing unchanged.
// - RAM_OUT_REG_EN undefined: single registered stage, latency 1 as above.
// TESTING (DATA_WIDTH=8, ADDR_WIDTH=6 unless noted)
// - Reset release -> busy_out=1 for exactly 64 cycles then 0; reads of addr 0,31,63 -> data_out=0x00, valid_out=1.
// - Write 0xA5 @0x10, next cycle read @0x10 -> data_out=0xA5, valid_out pulse 1 cycle (2 with RAM_OUT_REG_EN).
// - Mem[0x05]=0x11, write 0x22 @0x05: mode 0 -> data_out=0x11; mode 1 -> 0x22; mode 2 -> unchanged, valid_out=0.
// - Write 0x3C @0x20 during CLEAR (cycle 10) -> ignored; read @0x20 after busy_out=0 -> 0x00.
// - Assert rst mid-stream of reads -> outputs 0 immediately, busy_out=1, CLEAR restarts, full 64 cycles.
// - DATA_WIDTH=16, ADDR_WIDTH=4: write 0xBEEF @0xF, read @0xF -> 0xBEEF; CLEAR lasts 16 cycles.

Source files
------------

// File: rtl/ram_single_port_param_if.sv
// ----------------------------------------------------------------------------
// ram_single_port_param_if
// Access bus for the single-port parametrised RAM.
//
// Signals
//   en_in      requester -> RAM  access request, sampled on each rising edge
//   we_in      requester -> RAM  1 = write, 0 = read (qualified by en_in)
//   addr_in    requester -> RAM  word address
//   data_in    requester -> RAM  write data
//   data_out   RAM -> requester  registered read / write-through data
//   valid_out  RAM -> requester  data_out holds the result of an accepted access
//   busy_out   RAM -> requester  post-reset clear running, requests are ignored
//
// Modports
//   master  the requesting datapath block
//   slave   the RAM itself
// ----------------------------------------------------------------------------
interface ram_single_port_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic                  en_in;
    logic                  we_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  busy_out;

    modport master (
        output en_in,
        output we_in,
        output addr_in,
        output data_in,
        input  data_out,
        input  valid_out,
        input  busy_out
    );

    modport slave (
        input  en_in,
        input  we_in,
        input  addr_in,
        input  data_in,
        output data_out,
        output valid_out,
        output busy_out
    );
endinterface

// File: rtl/ram_single_port_param.sv
// ----------------------------------------------------------------------------
// ram_single_port_param
// Parametrised single-port synchronous RAM with one shared address port.
// After every reset the array is zero-filled by a clear sequencer, one word
// per clock, before any access is accepted.
//
// Parameters
//   DATA_WIDTH  word width in bits
//   ADDR_WIDTH  address width, DEPTH = 2**ADDR_WIDTH words
//   WRITE_MODE  0 = READ_FIRST (old word out on write)
//               1 = WRITE_FIRST (new word out on write)
//               2 = NO_CHANGE (data_out held, no valid on write)
//
// Ports
//   clk   clock, every register updates on the rising edge
//   rst   asynchronous active-high reset, restarts the clear sequence
//   bus   ram_single_port_param_if.slave access bus (see interface header)
//
// Build option
//   RAM_OUT_REG_EN  when defined, adds one output pipeline stage so data_out
//                   and valid_out arrive two clocks after the request edge.
// ----------------------------------------------------------------------------
module ram_single_port_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int WRITE_MODE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    ram_single_port_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] clrAddr_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdData_q;
    logic                  rdValid_q;
    logic [DATA_WIDTH-1:0] rdData_d;
    logic                  rdValid_d;
    logic                  accept;
    logic                  writeEn;

    // Requests only count once the clear sequence has finished.
    assign accept  = (state_q == READY) && bus.en_in;
    assign writeEn = accept && bus.we_in;

    // Next value of the array read register. The array is read before this
    // edge's write lands, which is what gives READ_FIRST its old-data result.
    always_comb begin
        rdData_d  = rdData_q;
        rdValid_d = 1'b0;
        if (accept) begin
            if (!bus.we_in) begin
                rdData_d  = mem[bus.addr_in];
                rdValid_d = 1'b1;
            end else if (WRITE_MODE == 1) begin
                rdData_d  = bus.data_in;
                rdValid_d = 1'b1;
            end else if (WRITE_MODE != 2) begin
                rdData_d  = mem[bus.addr_in];
                rdValid_d = 1'b1;
            end
        end
    end

    // Storage array: zero-filled word by word while clearing, otherwise
    // written by accepted write requests. No reset so it maps onto RAM cells.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clrAddr_q] <= '0;
        end else if (writeEn) begin
            mem[bus.addr_in] <= bus.data_in;
        end
    end

    // Clear sequencer plus the registered read port. The clear address is
    // only advanced in CLEAR, so leaving on all-ones can never re-trigger it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clrAddr_q <= '0;
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clrAddr_q <= clrAddr_q + ADDR_WIDTH'(1);
                    if (&clrAddr_q) begin
                        state_q <= READY;
                    end
                end
                default: begin
                    state_q <= READY;
                end
            endcase
            rdData_q  <= rdData_d;
            rdValid_q <= rdValid_d;
        end
    end

    assign bus.busy_out = (state_q == CLEAR);

`ifdef RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] outData_q;
    logic                  outValid_q;

    // Extra output stage: captures a result only when one is present, so
    // data_out keeps holding the last result just like the single-stage build.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outData_q  <= '0;
            outValid_q <= 1'b0;
        end else begin
            outValid_q <= rdValid_q;
            if (rdValid_q) begin
                outData_q <= rdData_q;
            end
        end
    end

    assign bus.data_out  = outData_q;
    assign bus.valid_out = outValid_q;
`else
    assign bus.data_out  = rdData_q;
    assign bus.valid_out = rdValid_q;
`endif

endmodule
